// File: rtl/rom_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the boot ROM and rom_arbiter.
// slave is the arbiter's view; master is the requester/ROM environment's view.
interface rom_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic [15:0]       cpu_addr;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_fault;
  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_data;
  logic              rom_cs;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport slave (
    input  cpu_req, cpu_addr, dma_req, dma_addr, rom_data,
    output cpu_ack, cpu_data, cpu_fault, dma_ack, dma_data, rom_cs, rom_addr
  );

  modport master (
    output cpu_req, cpu_addr, dma_req, dma_addr, rom_data,
    input  cpu_ack, cpu_data, cpu_fault, dma_ack, dma_data, rom_cs, rom_addr
  );
endinterface

// File: rtl/rom_arbiter.sv
// Shares the boot ROM between the CPU (primary) and DMA (secondary) read ports.
// Each access is IDLE (arbitrate) -> READ (chip select) -> DONE (ack), all outputs registered.
module rom_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  rom_arbiter_if.slave bus
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t            state, state_nxt;
  logic              owner_dma, owner_dma_nxt;
  logic              fault_q, fault_nxt;
  logic [WCW-1:0]    wait_cnt, wait_cnt_nxt;

  logic              rom_cs_q, rom_cs_nxt;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_nxt;
  logic              cpu_ack_q, cpu_ack_nxt;
  logic              dma_ack_q, dma_ack_nxt;
  logic              cpu_fault_q, cpu_fault_nxt;
  logic [DATA_W-1:0] cpu_data_q, cpu_data_nxt;
  logic [DATA_W-1:0] dma_data_q, dma_data_nxt;

  logic              dma_win, cpu_win, cpu_out_of_window;
  logic [DATA_W-1:0] capture;

  // A starved DMA request overrides CPU priority once it has waited MAX_WAIT cycles.
  assign dma_win           = bus.dma_req && ((wait_cnt == WCW'(MAX_WAIT)) || !bus.cpu_req);
  assign cpu_win           = bus.cpu_req && !dma_win;
  assign cpu_out_of_window = (bus.cpu_addr[15:14] != 2'b00);
  assign capture           = fault_q ? '1 : bus.rom_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner_dma   <= 1'b0;
      fault_q     <= 1'b0;
      wait_cnt    <= '0;
      rom_cs_q    <= 1'b0;
      rom_addr_q  <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_fault_q <= 1'b0;
      cpu_data_q  <= '0;
      dma_data_q  <= '0;
    end else begin
      state       <= state_nxt;
      owner_dma   <= owner_dma_nxt;
      fault_q     <= fault_nxt;
      wait_cnt    <= wait_cnt_nxt;
      rom_cs_q    <= rom_cs_nxt;
      rom_addr_q  <= rom_addr_nxt;
      cpu_ack_q   <= cpu_ack_nxt;
      dma_ack_q   <= dma_ack_nxt;
      cpu_fault_q <= cpu_fault_nxt;
      cpu_data_q  <= cpu_data_nxt;
      dma_data_q  <= dma_data_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = (dma_win || cpu_win) ? READ : IDLE;
      READ:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so this block computes their next-cycle values.
  always_comb begin
    owner_dma_nxt = owner_dma;
    fault_nxt     = fault_q;
    rom_cs_nxt    = 1'b0;
    rom_addr_nxt  = rom_addr_q;
    cpu_ack_nxt   = 1'b0;
    dma_ack_nxt   = 1'b0;
    cpu_fault_nxt = 1'b0;
    cpu_data_nxt  = cpu_data_q;
    dma_data_nxt  = dma_data_q;
    case (state)
      IDLE: begin
        if (dma_win) begin
          owner_dma_nxt = 1'b1;
          fault_nxt     = 1'b0;
          rom_addr_nxt  = bus.dma_addr;
          rom_cs_nxt    = 1'b1;
        end else if (cpu_win) begin
          owner_dma_nxt = 1'b0;
          fault_nxt     = cpu_out_of_window;
          rom_addr_nxt  = bus.cpu_addr[ADDR_W-1:0];
          rom_cs_nxt    = !cpu_out_of_window;
        end
      end
      READ: begin
        if (owner_dma) begin
          dma_data_nxt = capture;
          dma_ack_nxt  = 1'b1;
        end else begin
          cpu_data_nxt  = capture;
          cpu_ack_nxt   = 1'b1;
          cpu_fault_nxt = fault_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (!bus.dma_req)
      wait_cnt_nxt = '0;
    else if (state == IDLE && dma_win)
      wait_cnt_nxt = '0;
    else if (state != IDLE && owner_dma)
      wait_cnt_nxt = wait_cnt;
    else if (wait_cnt != WCW'(MAX_WAIT))
      wait_cnt_nxt = wait_cnt + 1'b1;
  end

  assign bus.rom_cs    = rom_cs_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.cpu_fault = cpu_fault_q;
  assign bus.cpu_data  = cpu_data_q;
  assign bus.dma_data  = dma_data_q;

endmodule
